// File: rtl/cpu_pkg.sv
// Shared definitions for the execute/writeback slice: widths, op codes,
// FSM state encoding and op classification helpers.
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;

    localparam logic [3:0] OP_LD   = 4'd0;
    localparam logic [3:0] OP_SD   = 4'd1;
    localparam logic [3:0] OP_BEQ  = 4'd2;
    localparam logic [3:0] OP_BNE  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_XORI = 4'd5;
    localparam logic [3:0] OP_ORI  = 4'd6;
    localparam logic [3:0] OP_ANDI = 4'd7;
    localparam logic [3:0] OP_SLLI = 4'd8;
    localparam logic [3:0] OP_SRLI = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;
    localparam logic [3:0] OP_OR   = 4'd13;
    localparam logic [3:0] OP_AND  = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    typedef enum logic [1:0] {IDLE, MEM_REQ, RETIRE} state_e;

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_SD);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU: integer result for ALU ops and branch condition for
// BEQ/BNE. Memory and no-op codes produce a zero result.
module exe_alu #(
    parameter int DATA_W = 64
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_taken
);
    import cpu_pkg::*;

    always_comb begin
        o_result = '0;
        o_taken  = 1'b0;
        case (i_op)
            OP_BEQ:  o_taken  = (i_rs1 == i_rs2);
            OP_BNE:  o_taken  = (i_rs1 != i_rs2);
            OP_ADDI: o_result = i_rs1 + i_imm;
            OP_XORI: o_result = i_rs1 ^ i_imm;
            OP_ORI:  o_result = i_rs1 | i_imm;
            OP_ANDI: o_result = i_rs1 & i_imm;
            OP_SLLI: o_result = i_rs1 << i_imm[5:0];
            OP_SRLI: o_result = i_rs1 >> i_imm[5:0];
            OP_ADD:  o_result = i_rs1 + i_rs2;
            OP_SUB:  o_result = i_rs1 - i_rs2;
            OP_XOR:  o_result = i_rs1 ^ i_rs2;
            OP_OR:   o_result = i_rs1 | i_rs2;
            OP_AND:  o_result = i_rs1 & i_rs2;
            default: ;
        endcase
    end

endmodule

// File: rtl/exe_wb_unit.sv
// Execute/writeback stage: ALU, branch resolution and a req/ack data memory port.
// Optional EXE_WB_TIMEOUT_EN adds a 255-cycle memory timeout with sticky o_err.
module exe_wb_unit #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [4:0]        i_rd_id,
    input  logic [DATA_W-1:0] i_imm,
    input  logic              i_finish,
    output logic              o_ready,
    output logic              o_dm_req,
    output logic              o_dm_we,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [DATA_W-1:0] o_dm_wdata,
    input  logic              i_dm_ack,
    input  logic [DATA_W-1:0] i_dm_rdata,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd_id,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_br_valid,
    output logic              o_br_taken,
    output logic [ADDR_W-1:0] o_br_offset,
    output logic              o_done,
    output logic              o_finish,
    output logic              o_err
);
    import cpu_pkg::*;

    state_e            state_q, state_d;
    logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d, br_offset_q, br_offset_d;
    logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d, wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_id_q, wb_rd_id_d, pend_rd_q, pend_rd_d;
    logic              wb_valid_q, wb_valid_d, br_valid_q, br_valid_d;
    logic              br_taken_q, br_taken_d, done_q, done_d;
    logic              finish_q, finish_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_taken;
`ifdef EXE_WB_TIMEOUT_EN
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    exe_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_result(alu_res), .o_taken(alu_taken)
    );

    always_comb begin
        state_d     = state_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_wdata_d  = dm_wdata_q;
        pend_rd_d   = pend_rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_id_d  = wb_rd_id_q;
        wb_data_d   = wb_data_q;
        br_valid_d  = 1'b0;
        br_taken_d  = br_taken_q;
        br_offset_d = br_offset_q;
        done_d      = 1'b0;
        finish_d    = finish_q | i_finish;
`ifdef EXE_WB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid && is_mem(i_op)) begin
                    state_d    = MEM_REQ;
                    dm_req_d   = 1'b1;
                    dm_we_d    = (i_op == OP_SD);
                    dm_addr_d  = ADDR_W'(i_rs1 + i_imm);
                    dm_wdata_d = i_rs2;
                    pend_rd_d  = i_rd_id;
`ifdef EXE_WB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end else if (i_valid) begin
                    state_d = RETIRE;
                    done_d  = 1'b1;
                    if (is_branch(i_op)) begin
                        br_valid_d  = 1'b1;
                        br_taken_d  = alu_taken;
                        br_offset_d = ADDR_W'(i_imm << 1);
                    end else if (i_op != OP_NOP && i_rd_id != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_id_d = i_rd_id;
                        wb_data_d  = alu_res;
                    end
                end
            end
            MEM_REQ: begin
                if (i_dm_ack) begin
                    state_d  = RETIRE;
                    dm_req_d = 1'b0;
                    done_d   = 1'b1;
                    if (!dm_we_q && pend_rd_q != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_id_d = pend_rd_q;
                        wb_data_d  = i_dm_rdata;
                    end
`ifdef EXE_WB_TIMEOUT_EN
                // cnt_q == 254 marks the 255th cycle spent waiting
                end else if (cnt_q == 8'd254) begin
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            pend_rd_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_id_q  <= '0;
            wb_data_q   <= '0;
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            br_offset_q <= '0;
            done_q      <= 1'b0;
            finish_q    <= 1'b0;
`ifdef EXE_WB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            pend_rd_q   <= pend_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_id_q  <= wb_rd_id_d;
            wb_data_q   <= wb_data_d;
            br_valid_q  <= br_valid_d;
            br_taken_q  <= br_taken_d;
            br_offset_q <= br_offset_d;
            done_q      <= done_d;
            finish_q    <= finish_d;
`ifdef EXE_WB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_dm_req    = dm_req_q;
    assign o_dm_we     = dm_we_q;
    assign o_dm_addr   = dm_addr_q;
    assign o_dm_wdata  = dm_wdata_q;
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_rd_id  = wb_rd_id_q;
    assign o_wb_data   = wb_data_q;
    assign o_br_valid  = br_valid_q;
    assign o_br_taken  = br_taken_q;
    assign o_br_offset = br_offset_q;
    assign o_done      = done_q;
    assign o_finish    = finish_q;
`ifdef EXE_WB_TIMEOUT_EN
    assign o_err       = err_q;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_exe_wb_unit.sv
// Directed-vector bench for exe_wb_unit; timeout path checked when
// EXE_WB_TIMEOUT_EN is defined, indefinite wait checked otherwise.
module tb_exe_wb_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, finish = 1'b0, dm_ack = 1'b0;
    logic [3:0]  op = '0;
    logic [63:0] rs1 = '0, rs2 = '0, imm = '0, dm_rdata = '0;
    logic [4:0]  rd_id = '0;
    logic        ready, dm_req, dm_we, wb_valid, br_valid, br_taken, done, fin, err;
    logic [63:0] dm_addr, dm_wdata, wb_data, br_offset;
    logic [4:0]  wb_rd_id;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    exe_wb_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_op(op),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd_id(rd_id), .i_imm(imm),
        .i_finish(finish), .o_ready(ready), .o_dm_req(dm_req), .o_dm_we(dm_we),
        .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata), .i_dm_ack(dm_ack),
        .i_dm_rdata(dm_rdata), .o_wb_valid(wb_valid), .o_wb_rd_id(wb_rd_id),
        .o_wb_data(wb_data), .o_br_valid(br_valid), .o_br_taken(br_taken),
        .o_br_offset(br_offset), .o_done(done), .o_finish(fin), .o_err(err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one instruction for a single cycle; returns at the negedge of N+1.
    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] im);
        @(negedge clk);
        valid = 1'b1; op = o; rs1 = a; rs2 = b; rd_id = rd; imm = im;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", ready, 1); chk("rst_req", dm_req, 0);
        chk("rst_wb_valid", wb_valid, 0); chk("rst_done", done, 0);
        chk("rst_finish", fin, 0); chk("rst_err", err, 0);
        chk("rst_wb_data", wb_data, 0); chk("rst_br_valid", br_valid, 0);
        @(negedge clk); rst_n = 1'b1;

        issue(OP_ADDI, 64'd5, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("addi_wbv", wb_valid, 1); chk("addi_rd", wb_rd_id, 7);
        chk("addi_data", wb_data, 2); chk("addi_done", done, 1);
        chk("addi_ready_n1", ready, 0);
        @(negedge clk);
        chk("addi_ready_n2", ready, 1); chk("addi_wbv_n2", wb_valid, 0);
        chk("addi_done_n2", done, 0);

        issue(OP_SUB, 64'd0, 64'd1, 5'd3, 64'd0);
        chk("sub_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(OP_SRLI, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd4, 64'd60);
        chk("srli_data", wb_data, 64'hF); chk("srli_rd", wb_rd_id, 4);
        issue(OP_SLLI, 64'h3, 64'd0, 5'd4, 64'd62);
        chk("slli_data", wb_data, 64'hC000_0000_0000_0000);

        issue(OP_BNE, 64'd3, 64'd4, 5'd0, 64'd8);
        chk("bne_valid", br_valid, 1); chk("bne_taken", br_taken, 1);
        chk("bne_offset", br_offset, 16); chk("bne_wbv", wb_valid, 0);
        chk("bne_done", done, 1);
        issue(OP_BEQ, 64'd3, 64'd4, 5'd0, 64'd8);
        chk("beq_valid", br_valid, 1); chk("beq_taken", br_taken, 0);

        // Load with ack after three wait cycles.
        issue(OP_LD, 64'h100, 64'd0, 5'd9, 64'd8);
        chk("ld_req_n1", dm_req, 1); chk("ld_addr", dm_addr, 64'h108);
        chk("ld_we", dm_we, 0); chk("ld_ready", ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ld_req_held", dm_req, 1); chk("ld_done_early", done, 0);
        end
        dm_ack = 1'b1; dm_rdata = 64'hDEAD;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("ld_req_drop", dm_req, 0); chk("ld_wbv", wb_valid, 1);
        chk("ld_data", wb_data, 64'hDEAD); chk("ld_rd", wb_rd_id, 9);
        chk("ld_done", done, 1);
        @(negedge clk);
        chk("ld_ready_after", ready, 1);

        // Store with a second instruction pulsed while busy (must be dropped).
        issue(OP_SD, 64'h200, 64'h55, 5'd0, 64'd0);
        chk("sd_req", dm_req, 1); chk("sd_we", dm_we, 1);
        chk("sd_wdata", dm_wdata, 64'h55); chk("sd_addr", dm_addr, 64'h200);
        valid = 1'b1; op = OP_ADD; rs1 = 64'd1; rs2 = 64'd1; rd_id = 5'd5;
        @(negedge clk);
        valid = 1'b0; dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("sd_done", done, 1); chk("sd_wbv", wb_valid, 0); chk("sd_req_drop", dm_req, 0);
        @(negedge clk);
        chk("drop_ready", ready, 1); chk("drop_req", dm_req, 0);
        chk("drop_wbv", wb_valid, 0); chk("drop_done", done, 0);

        // Stray ack in IDLE must not retire anything.
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("stray_ack_done", done, 0); chk("stray_ack_ready", ready, 1);

        issue(OP_ADD, 64'd1, 64'd2, 5'd0, 64'd0);
        chk("rd0_done", done, 1); chk("rd0_wbv", wb_valid, 0);
        issue(OP_AND, 64'hF0F0, 64'h0FF0, 5'd31, 64'd0);
        chk("and_data", wb_data, 64'h00F0); chk("and_rd", wb_rd_id, 31);

        @(negedge clk); finish = 1'b1;
        @(negedge clk); finish = 1'b0;
        chk("finish_set", fin, 1);
        repeat (3) @(negedge clk);
        chk("finish_sticky", fin, 1);

        // Reset mid-transaction.
        issue(OP_LD, 64'h40, 64'd0, 5'd2, 64'd0);
        chk("rst_mid_req_before", dm_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", dm_req, 0); chk("rst_mid_finish", fin, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", ready, 1); chk("rst_mid_done", done, 0);

        issue(OP_LD, 64'h80, 64'd0, 5'd6, 64'd0);
`ifdef EXE_WB_TIMEOUT_EN
        repeat (254) @(negedge clk);
        chk("tmo_err_before", err, 0); chk("tmo_req_before", dm_req, 1);
        @(negedge clk);
        chk("tmo_err", err, 1); chk("tmo_req", dm_req, 0);
        chk("tmo_ready", ready, 1); chk("tmo_done", done, 0); chk("tmo_wbv", wb_valid, 0);
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", err, 1);
`else
        repeat (300) @(negedge clk);
        chk("wait_req", dm_req, 1); chk("wait_err", err, 0); chk("wait_ready", ready, 0);
        dm_ack = 1'b1; dm_rdata = 64'h1234;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("wait_ld_data", wb_data, 64'h1234); chk("wait_done", done, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_wb_unit.md
# exe_wb_unit

- Consumes the decoded, operand-read instruction stream produced by the decode/register-read stage, i.e. {op, rs1, rs2, rd_id, imm, valid, finish}.
- Performs ALU operations, branch resolution and 64-bit data memory load/store over a request/acknowledge handshake.
- Returns register writeback (valid, rd_id, data) to the decode stage's register file.
- Sits between decode and the data memory, and reports branch outcome and retirement to fetch.

## Interface
- ADDR_W, 64, data memory address width
- DATA_W, 64, operand/result width
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  decoded instruction valid (one-cycle pulse)
- i_op  in  4  op code 0..14 (encoding in package)
- i_rs1, i_rs2  in  DATA_W  register operands
- i_rd_id  in  5  destination register
- i_imm  in  DATA_W  sign-extended immediate; for branches it is offset>>1
- i_finish  in  1  stop instruction seen
- o_ready  out  1  unit idle, may accept i_valid
- o_dm_req  out  1  data memory request, held until ack
- o_dm_we  out  1  1 = store, 0 = load
- o_dm_addr  out  ADDR_W  rs1 + imm
- o_dm_wdata  out  DATA_W  rs2 (stores)
- i_dm_ack  in  1  memory done; for loads, rdata valid this cycle
- i_dm_rdata  in  DATA_W  load data
- o_wb_valid  out  1  writeback strobe to register file
- o_wb_rd_id  out  5  writeback register
- o_wb_data  out  DATA_W  writeback value
- o_br_valid  out  1  branch resolved
- o_br_taken  out  1  branch taken
- o_br_offset  out  ADDR_W  byte offset = imm << 1
- o_done  out  1  instruction retired pulse
- o_finish  out  1  registered i_finish, sticky until reset
- o_err  out  1  memory timeout flag (see Configuration)

## Operation
- Op codes: 0 LD, 1 SD, 2 BEQ, 3 BNE, 4 ADDI, 5 XORI, 6 ORI, 7 ANDI, 8 SLLI, 9 SRLI, 10 ADD, 11 SUB, 12 XOR, 13 OR, 14 AND; 15 retires as no-op.
- FSM states: IDLE, MEM_REQ, RETIRE.
- IDLE, i_valid with an ALU or branch op: register the result and go to RETIRE.
- IDLE, i_valid with LD/SD: latch addr, wdata and we, then go to MEM_REQ.
- MEM_REQ: o_dm_req=1. On i_dm_ack, capture rdata (LD) and go to RETIRE.
- RETIRE: one cycle. Assert o_done, plus o_wb_valid (ALU/LD) or o_br_valid (branch), then return to IDLE.
- o_ready = (state==IDLE). i_valid while not ready is dropped.
- i_dm_ack outside MEM_REQ is ignored.
- Writeback is suppressed (o_wb_valid=0) when rd_id==0; o_done still pulses.
- Arithmetic is modulo 2^DATA_W.
- SLLI/SRLI use shamt = imm[5:0]; SRLI is a logical shift.
- SUB = rs1 - rs2.
- BEQ is taken iff rs1==rs2; BNE is taken iff rs1!=rs2.
- No address alignment check.
- o_finish set when i_finish=1 in any state; cleared only by reset.

## Timing
- Reset: every output 0 except o_ready=1; FSM to IDLE.
- Reset asserted mid-transaction drops o_dm_req immediately; the pending instruction is discarded.
- ALU/branch: i_valid at cycle N gives o_wb_valid/o_br_valid/o_done at N+1. o_ready is 0 at N+1 and 1 at N+2.
- LD/SD: i_valid at N gives o_dm_req from N+1. With ack at cycle M≥N+1, retirement (and LD writeback) is at M+1 and req drops at M+1.
- Back-to-back ALU throughput: 1 instruction per 2 cycles.
- All strobes are single-cycle pulses. Data outputs hold their last value otherwise (reset 0).

## Configuration
- EXE_WB_TIMEOUT_EN defined: an 8-bit counter runs in MEM_REQ.
  - After 255 cycles without ack, go to IDLE with no writeback and no o_done.
  - o_err is set sticky until reset.
  - The counter clears on entry to MEM_REQ.
- EXE_WB_TIMEOUT_EN undefined: MEM_REQ waits indefinitely; o_err is tied 0.

## Structure
- Package cpu_pkg holds: op code localparams (OP_LD..OP_AND), state enum, and DATA_W/ADDR_W defaults.
- Sub-module exe_alu is combinational: (op, rs1, rs2, imm) -> result, branch_taken.

## Test plan
- ADDI: rs1=5, imm=-3, rd=7 -> N+1: o_wb_valid=1, rd_id=7, data=2, o_done=1.
- SUB then SRLI:
  - SUB rs1=0, rs2=1 -> data=0xFFFF_FFFF_FFFF_FFFF.
  - SRLI of that value, imm=60 -> data=0xF.
- BNE rs1=3, rs2=4, imm=8 -> o_br_valid=1, taken=1, offset=16. BEQ with the same operands -> taken=0.
- LD: rs1=0x100, imm=8; ack after 3 wait cycles with rdata=0xDEAD -> addr=0x108, we=0, req held 4 cycles, writeback 0xDEAD the cycle after ack.
- SD: rs2=0x55 with i_valid pulsed while busy -> second instruction dropped, single store of 0x55; ADD with rd=0 -> o_done=1, o_wb_valid=0.
- Reset asserted during MEM_REQ -> o_dm_req=0 immediately, o_ready=1 after release. With EXE_WB_TIMEOUT_EN and no ack -> o_err=1 after 255 cycles.
